// File: rtl/tally_reader.sv
// Purpose    : event tally with a BCD readout engine (binary-to-BCD shift-add-3).
// Latency    : dout_valid rises 8 cycles after the rd_req acceptance edge.
// Backpressure: result held stable in HOLD until dout_ready; rd_req ignored while busy.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   inc, clr            tally increment / synchronous clear (clr wins)
//   rd_req              start a readout of the current tally (honoured in IDLE only)
//   dout_ready          consumer accepts the held readout
//   busy                readout in progress (CONV or HOLD)
//   dout_valid          hundreds/tens/ones hold a valid BCD readout
//   hundreds/tens/ones  BCD digits of the snapshotted tally
//   tally               live 8-bit tally
//   overflow            sticky saturation flag
//
// Build option: define TALLY_SATURATE_EN to make the tally saturate at 255 and
// set the sticky overflow flag; otherwise the tally wraps and overflow is 0.

module tally_reader (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clr,
    input  logic       rd_req,
    input  logic       dout_ready,
    output logic       busy,
    output logic       dout_valid,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [7:0] tally,
    output logic       overflow
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam logic [3:0] LAST_SHIFT = 4'd7;

    logic [1:0]  state;
    // {hundreds[19:16], tens[15:12], ones[11:8], binary[7:0]}
    logic [19:0] shift_q;
    logic [3:0]  cyc_q;
    logic [19:0] shift_adj;
    logic [19:0] shift_nxt;

    // ------------------------------------------------------------------
    // Tally counter: runs in every FSM state, independent of the readout.
    // ------------------------------------------------------------------
`ifdef TALLY_SATURATE_EN
    logic overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tally      <= 8'd0;
            overflow_q <= 1'b0;
        end else if (clr) begin
            tally      <= 8'd0;
            overflow_q <= 1'b0;
        end else if (inc) begin
            if (tally == 8'hFF) begin
                overflow_q <= 1'b1;
            end else begin
                tally <= tally + 8'd1;
            end
        end
    end

    assign overflow = overflow_q;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tally <= 8'd0;
        end else if (clr) begin
            tally <= 8'd0;
        end else if (inc) begin
            tally <= tally + 8'd1;
        end
    end

    assign overflow = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Shift-add-3 datapath: adjust every BCD nibble >= 5, then shift left.
    // ------------------------------------------------------------------
    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

    always_comb begin
        shift_adj = {add3(shift_q[19:16]), add3(shift_q[15:12]),
                     add3(shift_q[11:8]), shift_q[7:0]};
        shift_nxt = shift_adj << 1;
    end

    // ------------------------------------------------------------------
    // Readout FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift_q    <= 20'd0;
            cyc_q      <= 4'd0;
            dout_valid <= 1'b0;
            hundreds   <= 4'd0;
            tens       <= 4'd0;
            ones       <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_req) begin
                        // Snapshot here so later inc/clr cannot disturb the readout.
                        shift_q <= {12'd0, tally};
                        cyc_q   <= 4'd0;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    shift_q <= shift_nxt;
                    if (cyc_q == LAST_SHIFT) begin
                        // Digits are taken from the post-shift value of the 8th step.
                        hundreds   <= shift_nxt[19:16];
                        tens       <= shift_nxt[15:12];
                        ones       <= shift_nxt[11:8];
                        dout_valid <= 1'b1;
                        cyc_q      <= 4'd0;
                        state      <= HOLD;
                    end else begin
                        cyc_q <= cyc_q + 4'd1;
                    end
                end
                HOLD: begin
                    if (dout_ready) begin
                        dout_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    dout_valid <= 1'b0;
                    cyc_q      <= 4'd0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == CONV) || (state == HOLD);

endmodule

// File: tb/tb_tally_reader.sv
module tb_tally_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inc = 1'b0;
    logic       clr = 1'b0;
    logic       rd_req = 1'b0;
    logic       dout_ready = 1'b0;
    logic       busy;
    logic       dout_valid;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [7:0] tally;
    logic       overflow;

    tally_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (inc),
        .clr        (clr),
        .rd_req     (rd_req),
        .dout_ready (dout_ready),
        .busy       (busy),
        .dout_valid (dout_valid),
        .hundreds   (hundreds),
        .tens       (tens),
        .ones       (ones),
        .tally      (tally),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural reference: tally as an integer, readout as
    // "busy since acceptance, result appears 8 edges later, digits by division".
    int m_tally, m_ovf, m_busy, m_valid, m_cnt, m_snap, m_h, m_t, m_o;

    task automatic model_reset();
        m_tally = 0; m_ovf = 0; m_busy = 0; m_valid = 0;
        m_cnt = 0; m_snap = 0; m_h = 0; m_t = 0; m_o = 0;
    endtask

    // Advance one clock edge and update the model from the inputs seen at that edge.
    task automatic tick();
        int nt, nov, nb, nv, nc, ns, nh, ntn, no;
        nt = m_tally; nov = m_ovf; nb = m_busy; nv = m_valid;
        nc = m_cnt; ns = m_snap; nh = m_h; ntn = m_t; no = m_o;
        if (clr) begin
            nt = 0; nov = 0;
        end else if (inc) begin
`ifdef TALLY_SATURATE_EN
            if (m_tally == 255) nov = 1;
            else nt = m_tally + 1;
`else
            nt = (m_tally + 1) % 256;
`endif
        end
        if (m_busy == 0) begin
            if (rd_req) begin
                nb = 1; ns = m_tally; nc = 0;
            end
        end else if (m_valid == 0) begin
            nc = m_cnt + 1;
            if (nc == 8) begin
                nv = 1;
                nh = m_snap / 100; ntn = (m_snap / 10) % 10; no = m_snap % 10;
            end
        end else if (dout_ready) begin
            nv = 0; nb = 0;
        end
        @(posedge clk);
        #1;
        m_tally = nt; m_ovf = nov; m_busy = nb; m_valid = nv;
        m_cnt = nc; m_snap = ns; m_h = nh; m_t = ntn; m_o = no;
    endtask

    task automatic apply_reset();
        inc = 0; clr = 0; rd_req = 0; dout_ready = 0;
        #2;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (tally !== 8'd0) begin n_err++; $display("FAIL reset_tally: got %0d want 0", tally); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", dout_valid); end
        n_cmp++; if ({hundreds, tens, ones} !== 12'h000) begin n_err++; $display("FAIL reset_digits: got %h%h%h want 000", hundreds, tens, ones); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_readout_234();
        apply_reset();
        inc = 1; repeat (234) tick(); inc = 0;
        rd_req = 1; tick(); rd_req = 0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL r234_busy: got %b want 1", busy); end
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_cmp++;
            if (dout_valid !== (i == 8)) begin
                n_err++; $display("FAIL r234_latency cycle %0d: valid got %b want %b", i, dout_valid, (i == 8));
            end
        end
        n_cmp++; if ({hundreds, tens, ones} !== 12'h234) begin n_err++; $display("FAIL r234_digits: got %h%h%h want 234", hundreds, tens, ones); end
        n_cmp++; if (tally !== 8'd234) begin n_err++; $display("FAIL r234_tally: got %0d want 234", tally); end
        dout_ready = 1; tick(); dout_ready = 0;
        n_cmp++; if (busy !== 1'b0 || dout_valid !== 1'b0) begin n_err++; $display("FAIL r234_release: busy %b valid %b want 0 0", busy, dout_valid); end
    endtask

    task automatic test_values();
        int vals[8];
        vals[0] = 0; vals[1] = 99; vals[2] = 100; vals[3] = 255; vals[4] = 9; vals[5] = 10;
        vals[6] = int'($urandom_range(0, 255)); vals[7] = int'($urandom_range(0, 255));
        foreach (vals[k]) begin
            apply_reset();
            inc = 1; repeat (vals[k]) tick(); inc = 0;
            rd_req = 1; tick(); rd_req = 0;
            repeat (8) tick();
            n_cmp++;
            if (dout_valid !== 1'b1 || hundreds !== 4'(vals[k] / 100) || tens !== 4'((vals[k] / 10) % 10)
                || ones !== 4'(vals[k] % 10)) begin
                n_err++;
                $display("FAIL values_%0d: valid %b digits %0d/%0d/%0d want 1 %0d/%0d/%0d", vals[k], dout_valid,
                         hundreds, tens, ones, vals[k] / 100, (vals[k] / 10) % 10, vals[k] % 10);
            end
            n_cmp++; if (hundreds > 4'd2 || tens > 4'd9 || ones > 4'd9) begin n_err++; $display("FAIL values_range_%0d: got %0d/%0d/%0d want h<=2 t,o<=9", vals[k], hundreds, tens, ones); end
            dout_ready = 1; tick(); dout_ready = 0;
        end
    endtask

    task automatic test_hold();
        int v, eh, et, eo;
        apply_reset();
        v = int'($urandom_range(20, 200));
        eh = v / 100; et = (v / 10) % 10; eo = v % 10;
        inc = 1; repeat (v) tick(); inc = 0;
        rd_req = 1; tick(); rd_req = 0;
        repeat (8) tick();
        for (int i = 0; i < 5; i++) begin
            inc = i[0];
            tick();
            n_cmp++;
            if (dout_valid !== 1'b1 || hundreds !== 4'(eh) || tens !== 4'(et) || ones !== 4'(eo)) begin
                n_err++; $display("FAIL hold_stable cycle %0d: valid %b digits %0d/%0d/%0d want 1 %0d/%0d/%0d",
                                  i, dout_valid, hundreds, tens, ones, eh, et, eo);
            end
            n_cmp++; if (tally !== 8'(m_tally)) begin n_err++; $display("FAIL hold_tally cycle %0d: got %0d want %0d", i, tally, m_tally); end
        end
        inc = 0;
        // rd_req at the handshake edge must not be taken; it is accepted one edge later.
        dout_ready = 1; rd_req = 1; tick(); dout_ready = 0;
        n_cmp++; if (busy !== 1'b0 || dout_valid !== 1'b0) begin n_err++; $display("FAIL hold_release: busy %b valid %b want 0 0", busy, dout_valid); end
        tick(); rd_req = 0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL hold_next_accept: busy got %b want 1", busy); end
        repeat (8) tick();
        n_cmp++; if (dout_valid !== 1'b1 || ones !== 4'(m_o) || tens !== 4'(m_t)) begin n_err++; $display("FAIL hold_second_read: valid %b digits %0d%0d want 1 %0d%0d", dout_valid, tens, ones, m_t, m_o); end
        dout_ready = 1; tick(); dout_ready = 0;
    endtask

    task automatic test_clr_priority();
        apply_reset();
        inc = 1; repeat (17) tick();
        clr = 1; tick(); clr = 0; inc = 0;
        n_cmp++; if (tally !== 8'd0) begin n_err++; $display("FAIL clr_priority: tally got %0d want 0", tally); end
        inc = 1; repeat (42) tick();
        rd_req = 1; tick(); rd_req = 0;
        repeat (2) tick();
        rd_req = 1; tick(); rd_req = 0;
        repeat (5) tick();
        inc = 0;
        n_cmp++; if (dout_valid !== 1'b1 || {hundreds, tens, ones} !== 12'h042) begin n_err++; $display("FAIL conv_ignore_rd: valid %b digits %h%h%h want 1 042", dout_valid, hundreds, tens, ones); end
        n_cmp++; if (tally !== 8'(m_tally)) begin n_err++; $display("FAIL conv_tally: got %0d want %0d", tally, m_tally); end
        dout_ready = 1; tick(); dout_ready = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_cmp++; if (busy !== 1'b0 || dout_valid !== 1'b0) begin n_err++; $display("FAIL no_second_read cycle %0d: busy %b valid %b want 0 0", i, busy, dout_valid); end
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        inc = 1; repeat (256) tick(); inc = 0;
`ifdef TALLY_SATURATE_EN
        n_cmp++; if (tally !== 8'd255 || overflow !== 1'b1) begin n_err++; $display("FAIL sat_256: tally %0d ovf %b want 255 1", tally, overflow); end
`else
        n_cmp++; if (tally !== 8'd0 || overflow !== 1'b0) begin n_err++; $display("FAIL wrap_256: tally %0d ovf %b want 0 0", tally, overflow); end
`endif
        rd_req = 1; tick(); rd_req = 0;
        repeat (8) tick();
`ifdef TALLY_SATURATE_EN
        n_cmp++; if ({hundreds, tens, ones} !== 12'h255) begin n_err++; $display("FAIL sat_digits: got %h%h%h want 255", hundreds, tens, ones); end
`else
        n_cmp++; if ({hundreds, tens, ones} !== 12'h000) begin n_err++; $display("FAIL wrap_digits: got %h%h%h want 000", hundreds, tens, ones); end
`endif
        dout_ready = 1; tick(); dout_ready = 0;
        clr = 1; tick(); clr = 0;
        n_cmp++; if (overflow !== 1'b0 || tally !== 8'd0) begin n_err++; $display("FAIL ovf_clr: tally %0d ovf %b want 0 0", tally, overflow); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        inc = 1; repeat (123) tick(); inc = 0;
        rd_req = 1; tick(); rd_req = 0;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (busy !== 1'b0 || dout_valid !== 1'b0 || tally !== 8'd0 || overflow !== 1'b0
            || {hundreds, tens, ones} !== 12'h000) begin
            n_err++; $display("FAIL async_reset: busy %b valid %b tally %0d ovf %b digits %h%h%h want all 0",
                              busy, dout_valid, tally, overflow, hundreds, tens, ones);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++; if (busy !== 1'b0 || dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_abort cycle %0d: busy %b valid %b want 0 0", i, busy, dout_valid); end
        end
        inc = 1; repeat (57) tick(); inc = 0;
        rd_req = 1; tick(); rd_req = 0;
        repeat (8) tick();
        n_cmp++; if (dout_valid !== 1'b1 || {hundreds, tens, ones} !== 12'h057) begin n_err++; $display("FAIL reset_then_read: valid %b digits %h%h%h want 1 057", dout_valid, hundreds, tens, ones); end
        dout_ready = 1; tick(); dout_ready = 0;
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            inc        = 1'($urandom_range(0, 3) != 0);
            clr        = 1'($urandom_range(0, 63) == 0);
            rd_req     = 1'($urandom_range(0, 3) == 0);
            dout_ready = 1'($urandom_range(0, 2) == 0);
            tick();
            n_cmp++;
            if (tally !== 8'(m_tally) || overflow !== 1'(m_ovf) || busy !== 1'(m_busy)
                || dout_valid !== 1'(m_valid) || hundreds !== 4'(m_h) || tens !== 4'(m_t) || ones !== 4'(m_o)) begin
                n_err++;
                $display("FAIL random cycle %0d: tally %0d ovf %b busy %b valid %b digits %0d/%0d/%0d want %0d %0d %0d %0d %0d/%0d/%0d",
                         i, tally, overflow, busy, dout_valid, hundreds, tens, ones,
                         m_tally, m_ovf, m_busy, m_valid, m_h, m_t, m_o);
            end
        end
        inc = 0; clr = 0; rd_req = 0; dout_ready = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_readout_234();
        test_values();
        test_hold();
        test_clr_priority();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tally_reader.md
TALLY_READER -- requirements
Module: tally_reader

Interface
REQ-001 The block SHALL use the following ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- inc  in  1  increment request (one count per cycle high)
- clr  in  1  synchronous clear of tally
- rd_req  in  1  readout request
- dout_ready  in  1  consumer accepts readout
- busy  out  1  readout in progress (state != IDLE)
- dout_valid  out  1  BCD readout valid
- hundreds  out  4  BCD hundreds digit
- tens  out  4  BCD tens digit
- ones  out  4  BCD ones digit
- tally  out  8  live tally register
- overflow  out  1  sticky saturation flag
REQ-002 The block SHALL use one clock (clk) and an asynchronous, active-low reset (rst_n).

Function
REQ-003 The tally SHALL increment by 1 at each rising edge where inc=1 and clr=0.
REQ-004 clr=1 SHALL load tally=0 and overflow=0 at the next edge, taking priority over a simultaneous inc.
REQ-005 The FSM SHALL have exactly three states: IDLE, CONV and HOLD.
REQ-006 In IDLE, rd_req=1 SHALL snapshot tally into an internal shift register and enter CONV at the same edge.
REQ-007 rd_req SHALL be ignored in CONV and HOLD.
REQ-008 CONV SHALL run binary-to-BCD shift-add-3 for exactly 8 cycles.
- Before each shift, every BCD nibble that is >=5 gets +3.
- A 4-bit cycle counter sequences the 8 shifts.
REQ-009 At the 8th CONV edge, the FSM SHALL register hundreds, tens and ones, set dout_valid=1 and enter HOLD.
- dout_valid rises 8 cycles after the rd_req acceptance edge.
REQ-010 In HOLD, dout_valid and all digits SHALL stay stable until dout_ready=1.
REQ-011 dout_valid=1 with dout_ready=1 SHALL return the FSM to IDLE and clear dout_valid at that edge.
- A new rd_req is accepted no earlier than the following edge.
REQ-012 inc and clr SHALL keep acting on tally in every state without altering a conversion in progress or a held result.
REQ-013 busy SHALL be 1 exactly when the FSM is in CONV or HOLD.
REQ-014 hundreds SHALL be in the range 0..2 and tens and ones in the range 0..9 for every tally value 0..255.

Reset
REQ-015 rst_n=0 SHALL immediately force the following, regardless of clk:
- FSM to IDLE
- tally=0, overflow=0, busy=0, dout_valid=0
- hundreds, tens and ones = 0
- internal shift and cycle counters = 0
REQ-016 Reset asserted mid-CONV or mid-HOLD SHALL abort the readout with no residual valid after release.
REQ-017 After rst_n deasserts, the first active edge SHALL behave as from IDLE.

Configuration
REQ-018 With macro TALLY_SATURATE_EN defined, the tally SHALL hold at 255 when inc=1, and overflow SHALL set and stay 1 until clr or reset.
REQ-019 Without TALLY_SATURATE_EN, the tally SHALL wrap 255 -> 0 on inc, and overflow SHALL be constant 0.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Reset, 234 inc pulses, rd_req one cycle -> busy=1; dout_valid=1 after 8 cycles; digits 2/3/4; tally=234.
- tally=0, rd_req -> 0/0/0 after 8 cycles; tally=99 -> 0/9/9; tally=100 -> 1/0/0.
- Result held with dout_ready=0 for 5 cycles while inc toggles -> digits stable; tally advances; dout_ready=1 -> IDLE next edge.
- inc=1 and clr=1 same cycle at tally=17 -> tally=0; rd_req during CONV -> ignored, no second readout.
- 256 inc pulses -> with TALLY_SATURATE_EN: tally=255, overflow=1, readout 2/5/5; without it: tally=0, overflow=0.
- rst_n low for 1 cycle in the 4th CONV cycle -> all outputs 0, IDLE; next rd_req completes normally.
